// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: shared FSM encoding and counter sizing for serial_addsub
package serial_addsub_pkg;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/serial_addsub_fa_cell.sv
// fa_cell: combinational 1-bit full adder
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic c
);
   assign s = a ^ b ^ cin;
   assign c = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: digit-serial adder/subtractor, DIGIT bits per cycle, LSB first
module serial_addsub
   import serial_addsub_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);
   localparam int N = WIDTH / DIGIT;
   localparam int CW = cnt_w(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);
   logic [1:0] st, nst;
   logic [WIDTH-1:0] ra, rb, acc;
   logic [WIDTH+DIGIT-1:0] cat;
   logic [DIGIT-1:0] sb, sum;
   logic [DIGIT:0] c;
   logic [CW-1:0] cnt;
   logic rsub, carry, last, take;
   assign sb = rb[DIGIT-1:0] ^ {DIGIT{rsub}};
   assign c[0] = carry;
   assign cat = {sum, acc};
   assign last = cnt == LAST;
   assign take = start && st != ST_RUN;
   genvar i;
   for (i = 0; i < DIGIT; i++) begin : g_fa
      fa_cell u_fa (.a(ra[i]), .b(sb[i]), .cin(c[i]), .s(sum[i]), .c(c[i+1]));
   end
   // state register
   always_ff @(posedge clk)
      st <= rst ? ST_IDLE : nst;
   // next state: DONE accepts a new start directly, no IDLE bubble
   always_comb
      nst = (st == ST_RUN) ? (last ? ST_DONE : ST_RUN) : (start ? ST_RUN : ST_IDLE);
   // handshake outputs decoded from state
   always_comb begin
      busy = st == ST_RUN;
      done = st == ST_DONE;
   end
   // operand shifters, carry, counter and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         ra <= '0;
         rb <= '0;
         acc <= '0;
         rsub <= 1'b0;
         carry <= 1'b0;
         cnt <= '0;
         s <= '0;
         cout <= 1'b0;
         ovf <= 1'b0;
      end else if (take) begin
         ra <= a;
         rb <= b;
         rsub <= sub;
         carry <= sub;
         cnt <= '0;
      end else if (st == ST_RUN) begin
         ra <= ra >> DIGIT;
         rb <= rb >> DIGIT;
         acc <= WIDTH'(cat >> DIGIT);
         carry <= c[DIGIT];
         cnt <= cnt + CW'(1);
         if (last) begin
            s <= WIDTH'(cat >> DIGIT);
            cout <= c[DIGIT];
            ovf <= c[DIGIT] ^ c[DIGIT-1];
         end
      end
   end
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: scoreboard bench for serial_addsub in three geometries
module tb_serial_addsub;
   typedef struct {
      logic [9:0] exp;
      int t0;
   } ent_t;
   logic clk = 0, rst = 1;
   logic start8 = 0, sub8 = 0, start2 = 0, sub2 = 0, start4 = 0, sub4 = 0;
   logic [7:0] a8 = 0, b8 = 0, s8;
   logic [3:0] a2 = 0, b2 = 0, s2, a4 = 0, b4 = 0, s4;
   logic busy8, done8, cout8, ovf8, busy2, done2, cout2, ovf2, busy4, done4, cout4, ovf4;
   int cyc = 0, total = 0, passed = 0;
   int bc[3];
   ent_t q[3][$];
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   serial_addsub #(.WIDTH(8), .DIGIT(1)) u8 (.clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .s(s8), .cout(cout8), .ovf(ovf8));
   serial_addsub #(.WIDTH(4), .DIGIT(2)) u42 (.clk(clk), .rst(rst), .start(start2), .sub(sub2), .a(a2), .b(b2),
      .busy(busy2), .done(done2), .s(s2), .cout(cout2), .ovf(ovf2));
   serial_addsub #(.WIDTH(4), .DIGIT(4)) u44 (.clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .s(s4), .cout(cout4), .ovf(ovf4));
   // reference: signed range test for ovf, unsigned compare for carry/no-borrow
   function automatic logic [9:0] model(input int w, input int a, input int b, input bit sub);
      int mask = (1 << w) - 1;
      int ua = a & mask;
      int ub = b & mask;
      int sa = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
      int sbv = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
      int r = sub ? sa - sbv : sa + sbv;
      bit ov = (r < -(1 << (w - 1))) || (r >= (1 << (w - 1)));
      bit co = sub ? (ua >= ub) : (ua + ub > mask);
      return {ov, co, 8'(r & mask)};
   endfunction
   task automatic chk(input string nm, input int got, input int exp);
      total++;
      if (got !== exp) $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, got, exp, cyc);
      else passed++;
   endtask
   task automatic push(input int id, input int w, input int a, input int b, input bit sub);
      q[id].push_back('{model(w, a, b, sub), cyc});
   endtask
   task automatic got_done(input int id, input logic [9:0] got, input int n);
      ent_t e;
      if (q[id].size() == 0) begin
         total++;
         $display("FAIL unexpected_done[%0d]: actual result %0h required no done pulse", id, got);
      end else begin
         e = q[id].pop_front();
         chk($sformatf("result[%0d]", id), got, e.exp);
         chk($sformatf("latency[%0d]", id), cyc - e.t0, n + 1);
         chk($sformatf("busy_cycles[%0d]", id), bc[id], n);
      end
      bc[id] = 0;
   endtask
   always @(negedge clk) begin
      if (rst) bc[0] = 0;
      else begin
         if (busy8) bc[0]++;
         if (done8) got_done(0, {ovf8, cout8, s8}, 8);
      end
   end
   always @(negedge clk) begin
      if (rst) bc[1] = 0;
      else begin
         if (busy2) bc[1]++;
         if (done2) got_done(1, {ovf2, cout2, 4'b0, s2}, 2);
      end
   end
   always @(negedge clk) begin
      if (rst) bc[2] = 0;
      else begin
         if (busy4) bc[2]++;
         if (done4) got_done(2, {ovf4, cout4, 4'b0, s4}, 1);
      end
   end
   task automatic issue8(input logic [7:0] ta, input logic [7:0] tb, input logic ts, input bit rec);
      @(posedge clk);
      #1;
      a8 = ta;
      b8 = tb;
      sub8 = ts;
      start8 = 1;
      if (rec) push(0, 8, ta, tb, ts);
      @(posedge clk);
      #1;
      start8 = 0;
   endtask
   task automatic wait8();
      for (int t = 0; t < 40 && !done8; t++) begin
         @(posedge clk);
         #1;
      end
      chk("done8_seen", done8, 1);
   endtask
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
   initial begin
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      chk("rst_busy", busy8, 0);
      chk("rst_done", done8, 0);
      chk("rst_s", s8, 0);
      chk("rst_cout", cout8, 0);
      chk("rst_ovf", ovf8, 0);
      issue8(8'h5A, 8'h3C, 0, 1);
      wait8();
      issue8(8'hFF, 8'h01, 0, 1);
      wait8();
      issue8(8'h10, 8'h20, 1, 1);
      wait8();
      issue8(8'h80, 8'h01, 1, 1);
      repeat (3) @(posedge clk);
      #1;
      a8 = 8'h33;
      b8 = 8'h44;
      sub8 = 0;
      start8 = 1;
      @(posedge clk);
      #1;
      start8 = 0;
      wait8();
      repeat (12) @(posedge clk);
      issue8(8'h12, 8'h34, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1;
      @(posedge clk);
      #1;
      rst = 0;
      chk("abort_busy", busy8, 0);
      chk("abort_done", done8, 0);
      chk("abort_s", s8, 0);
      chk("abort_cout", cout8, 0);
      chk("abort_ovf", ovf8, 0);
      repeat (15) @(posedge clk);
      issue8(8'h21, 8'h43, 0, 1);
      wait8();
      @(posedge clk);
      #1;
      a8 = 8'h01;
      b8 = 8'h01;
      sub8 = 0;
      start8 = 1;
      push(0, 8, 1, 1, 0);
      @(posedge clk);
      #1;
      a8 = 8'h02;
      b8 = 8'h03;
      wait8();
      push(0, 8, 2, 3, 0);
      @(posedge clk);
      #1;
      start8 = 0;
      wait8();
      for (int i = 0; i < 40; i++) begin
         issue8(8'($urandom), 8'($urandom), 1'($urandom), 1);
         wait8();
      end
      fork
         begin
            for (int i = 0; i < 512; i++) begin
               @(posedge clk);
               #1;
               a2 = 4'(i);
               b2 = 4'(i >> 4);
               sub2 = 1'(i >> 8);
               start2 = 1;
               push(1, 4, a2, b2, sub2);
               @(posedge clk);
               #1;
               start2 = 0;
               for (int t = 0; t < 20 && !done2; t++) begin
                  @(posedge clk);
                  #1;
               end
               chk("done2_seen", done2, 1);
            end
         end
         begin
            for (int i = 0; i < 512; i++) begin
               @(posedge clk);
               #1;
               a4 = 4'(i);
               b4 = 4'(i >> 4);
               sub4 = 1'(i >> 8);
               start4 = 1;
               push(2, 4, a4, b4, sub4);
               @(posedge clk);
               #1;
               start4 = 0;
               for (int t = 0; t < 20 && !done4; t++) begin
                  @(posedge clk);
                  #1;
               end
               chk("done4_seen", done4, 1);
            end
         end
      join
      repeat (5) @(posedge clk);
      chk("pending0", q[0].size(), 0);
      chk("pending1", q[1].size(), 0);
      chk("pending2", q[2].size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised, multi-cycle adder/subtractor built from a chain of DIGIT full-adder cells.
- Adds or subtracts two WIDTH-bit operands, DIGIT bits per clock, LSB first, under a start/busy/done handshake.
- Produces sum, carry-out and signed overflow.
- Datapath building block for the lab ALU and accumulator blocks; trades latency for area against a flat ripple adder.

Parameters:
- WIDTH, 8, operand and result width in bits; must be an integer multiple of DIGIT.
- DIGIT, 1, bits processed per RUN cycle; 1 <= DIGIT <= WIDTH.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- sub  input  1  0 = a+b, 1 = a-b; latched with the operands.
- a  input  WIDTH  operand A; latched at accepted start.
- b  input  WIDTH  operand B; latched at accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse: result valid and updated.
- s  output  WIDTH  sum/difference, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB; for subtract, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; it is sampled only on a clk rising edge.
- Reset values: state=IDLE, busy=0, done=0, s=0, cout=0, ovf=0; internal shift registers, carry and counter cleared.
- Reset has priority over everything, including mid-RUN. The operation is discarded, no done is issued, and the block returns to IDLE on the next edge.
- Let N = WIDTH/DIGIT.
- FSM states:
  - IDLE: start=1 at an edge latches a, b, sub, sets carry=sub and cnt=0, then goes to RUN.
  - RUN: each edge consumes the low DIGIT bits of A and B. If sub=1, the B slice is inverted. Sum bits shift into the top of the result shift register, carry updates, cnt increments. At cnt=N-1, go to DONE.
  - DONE: one cycle. If start=1 at this edge, the new operands are accepted and the next state is RUN (back-to-back, no IDLE bubble). Otherwise go to IDLE.
- busy = 1 in RUN only.
- done = 1 in DONE only.
- start in RUN is ignored. Operand changes after acceptance have no effect.
- Latency: start accepted at edge k -> RUN for edges k+1..k+N -> done=1 during the cycle after edge k+N. That is N+1 cycles from accept to done; throughput is one result per N+1 cycles.
- s, cout, ovf are registered. They load on the edge entering DONE, so they change in the same cycle done rises, and hold until the next DONE entry or reset. They are never partially updated.
- cout = carry out of bit WIDTH-1.
- ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1. The carry into the MSB is taken inside the final slice's cell chain.
- Subtraction is a + ~b + 1. Results are modulo 2^WIDTH with no saturation.
- DIGIT=WIDTH is legal: N=1, one RUN cycle.

Decomposition:
- Shared package holds:
  - FSM state encoding constants: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - A function/constant for the counter width, clog2(N) with a minimum of 1.
- One sub-module, fa_cell: combinational 1-bit full adder (a, b, cin -> s, c).
  - Instantiated DIGIT times in a generate chain.
  - The carry into the last cell of the chain is exported for ovf.
- The FSM, counter, shift registers and result registers live in serial_addsub.

Test Plan:
- WIDTH=8, DIGIT=1, add a=0x5A b=0x3C -> done exactly 9 cycles after accept; s=0x96, cout=0, ovf=1. busy high for exactly 8 cycles.
- Add a=0xFF b=0x01 -> s=0x00, cout=1, ovf=0. Then sub a=0x10 b=0x20 -> s=0xF0, cout=0, ovf=0.
- Sub a=0x80 b=0x01 -> s=0x7F, cout=1, ovf=1. Pulse start again 3 cycles into RUN with different operands -> ignored; the same result is reported with a single done pulse.
- Assert rst for one edge 4 cycles into RUN -> next cycle busy=0, done=0, s=0, cout=0, ovf=0, and no done follows. A new start then completes normally.
- Hold start=1 continuously with a=0x01, b=0x01, then a=0x02, b=0x03 -> done pulses every 9 cycles with s=0x02 then s=0x05. busy drops only during DONE cycles.
- WIDTH=4, DIGIT=2 and WIDTH=4, DIGIT=4: exhaustive 512 (a, b, sub) cases against a behavioural model -> all s/cout/ovf match. Latency is 3 and 2 cycles respectively.
